// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline hazard sources and the stall/flush controls returned to the pipeline.
// The controller takes the slave modport; the datapath (or bench) takes master.
interface pipeline_hazard_ctrl_if;
  logic [4:0] rs1Addr_id;
  logic [4:0] rs2Addr_id;
  logic       useRs1_id;
  logic       useRs2_id;
  logic [4:0] rdAddr_ex;
  logic       memRead_ex;
  logic       branchTaken_ex;
  logic       mcReq_ex;
  logic       mcDone;
  logic       mcStart;
  logic       pcWrite;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_flush;
  logic       exmem_bubble;
  logic [1:0] state;
  logic       mcTimeout;

  modport master (
    output rs1Addr_id, rs2Addr_id, useRs1_id, useRs2_id, rdAddr_ex, memRead_ex,
           branchTaken_ex, mcReq_ex, mcDone,
    input  mcStart, pcWrite, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble,
           state, mcTimeout
  );

  modport slave (
    input  rs1Addr_id, rs2Addr_id, useRs1_id, useRs2_id, rdAddr_ex, memRead_ex,
           branchTaken_ex, mcReq_ex, mcDone,
    output mcStart, pcWrite, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble,
           state, mcTimeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// squashing and multi-cycle unit holds with a timeout into a sticky HALT.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 7
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_MC_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT    = 2'd3;

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] MC_LAST    = CNT_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             timeout_q, timeout_nxt;

  logic load_use;
  logic mc_start, pc_write, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble;

  // Register x0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign load_use = hz.memRead_ex && (hz.rdAddr_ex != 5'd0) &&
                    ((hz.useRs1_id && (hz.rs1Addr_id == hz.rdAddr_ex)) ||
                     (hz.useRs2_id && (hz.rs2Addr_id == hz.rdAddr_ex)));

  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    timeout_nxt  = timeout_q;
    mc_start     = 1'b0;
    pc_write     = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;

    case (state_q)
      ST_RUN: begin
        cnt_nxt = '0;
        if (hz.branchTaken_ex) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = FLUSH_LOAD;
          end
        end else if (hz.mcReq_ex) begin
          mc_start     = 1'b1;
          pc_write     = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_bubble = 1'b1;
          state_nxt    = ST_MC_WAIT;
          cnt_nxt      = CNT_ONE;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end

      ST_FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (cnt_q <= CNT_ONE) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end

      // A done in the last allowed cycle still wins over the timeout.
      ST_MC_WAIT: begin
        if (hz.mcDone) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          pc_write     = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_bubble = 1'b1;
          if (cnt_q == MC_LAST) begin
            state_nxt   = ST_HALT;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        pc_write     = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_bubble = 1'b1;
      end
    endcase

    if (reset) begin
      mc_start     = 1'b0;
      pc_write     = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign hz.mcStart      = mc_start;
  assign hz.pcWrite      = pc_write;
  assign hz.ifid_en      = ifid_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_en      = idex_en;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_bubble = exmem_bubble;
  assign hz.state        = state_q;
  assign hz.mcTimeout    = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MC_TIMEOUT=8):
// a table of per-cycle vectors followed by hand-written timeout/HALT sequences.
module tb_pipeline_hazard_ctrl;
  localparam int FLUSH_CYCLES = 2;
  localparam int MC_TIMEOUT   = 8;
  localparam int CNT_W        = 7;

  // Control word order: mcStart pcWrite ifid_en ifid_flush idex_en idex_flush exmem_bubble
  localparam logic [6:0] C_RUN   = 7'b0110100;
  localparam logic [6:0] C_RST   = 7'b0001011;
  localparam logic [6:0] C_LU    = 7'b0000110;
  localparam logic [6:0] C_BR    = 7'b0111110;
  localparam logic [6:0] C_MCS   = 7'b1000001;
  localparam logic [6:0] C_STALL = 7'b0000001;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       mc;
    logic       done;
  } stim_t;

  typedef struct {
    stim_t      in;
    logic [6:0] ctl;
    logic [1:0] st;
    logic       to;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   nApplied = 0;
  int   nMiss    = 0;
  vec_t vecs[$];

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .MC_TIMEOUT  (MC_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  always #5 clk = ~clk;

  function automatic stim_t mkS(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic mr, input logic br, input logic mc, input logic done);
    stim_t s;
    s = '{rst, rs1, rs2, u1, u2, rd, mr, br, mc, done};
    return s;
  endfunction

  function automatic vec_t mkV(input stim_t s, input logic [6:0] ctl, input logic [1:0] st,
                               input logic to, input string name);
    vec_t v;
    v.in = s; v.ctl = ctl; v.st = st; v.to = to; v.name = name;
    return v;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    reset                = s.rst;
    hz.rs1Addr_id        = s.rs1;
    hz.rs2Addr_id        = s.rs2;
    hz.useRs1_id         = s.u1;
    hz.useRs2_id         = s.u2;
    hz.rdAddr_ex         = s.rd;
    hz.memRead_ex        = s.mr;
    hz.branchTaken_ex    = s.br;
    hz.mcReq_ex          = s.mc;
    hz.mcDone            = s.done;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] ctl, input logic [1:0] st,
                             input logic to);
    logic [9:0] got, exp;
    @(negedge clk);
    got = {hz.mcStart, hz.pcWrite, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
           hz.exmem_bubble, hz.state, hz.mcTimeout};
    exp = {ctl, st, to};
    nApplied++;
    if (got !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got ctl=%b state=%0d to=%b, expected ctl=%b state=%0d to=%b",
               name, got[9:3], got[2:1], got[0], exp[9:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic runVec(input stim_t s, input logic [6:0] ctl, input logic [1:0] st,
                        input logic to, input string name);
    applyStimulus(s);
    checkOutput(name, ctl, st, to);
  endtask

  initial begin
    stim_t idle, mcq;
    idle = mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mcq  = mkS(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    vecs.push_back(mkV(mkS(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_RST, 2'd0, 0, "reset_outputs"));
    vecs.push_back(mkV(idle, C_RUN, 2'd0, 0, "run_idle"));
    vecs.push_back(mkV(mkS(0, 5, 0, 1, 0, 5, 1, 0, 0, 0), C_LU, 2'd0, 0, "loaduse_rs1"));
    vecs.push_back(mkV(idle, C_RUN, 2'd0, 0, "loaduse_one_bubble"));
    vecs.push_back(mkV(mkS(0, 0, 0, 1, 0, 0, 1, 0, 0, 0), C_RUN, 2'd0, 0, "loaduse_x0"));
    vecs.push_back(mkV(mkS(0, 3, 7, 1, 1, 7, 1, 0, 0, 0), C_LU, 2'd0, 0, "loaduse_rs2"));
    vecs.push_back(mkV(mkS(0, 3, 7, 1, 0, 7, 1, 0, 0, 0), C_RUN, 2'd0, 0, "rs2_unused"));
    vecs.push_back(mkV(mkS(0, 5, 0, 1, 0, 5, 0, 0, 0, 0), C_RUN, 2'd0, 0, "not_a_load"));
    vecs.push_back(mkV(mkS(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_BR, 2'd0, 0, "branch_cycle1"));
    vecs.push_back(mkV(mkS(0, 5, 0, 1, 0, 5, 1, 0, 1, 0), C_BR, 2'd1, 0, "flush_ignores"));
    vecs.push_back(mkV(idle, C_RUN, 2'd0, 0, "flush_exit"));
    vecs.push_back(mkV(mkS(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_BR, 2'd0, 0, "branch_over_mc"));
    vecs.push_back(mkV(idle, C_BR, 2'd1, 0, "branch_mc_flush2"));
    vecs.push_back(mkV(idle, C_RUN, 2'd0, 0, "branch_mc_exit"));
    vecs.push_back(mkV(mcq, C_MCS, 2'd0, 0, "mc_start"));
    vecs.push_back(mkV(mkS(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_STALL, 2'd2, 0, "mc_wait1_br"));
    vecs.push_back(mkV(mcq, C_STALL, 2'd2, 0, "mc_wait2"));
    vecs.push_back(mkV(mcq, C_STALL, 2'd2, 0, "mc_wait3"));
    vecs.push_back(mkV(mkS(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_RUN, 2'd2, 0, "mc_done"));
    vecs.push_back(mkV(mkS(0, 9, 5, 1, 1, 9, 1, 0, 0, 0), C_LU, 2'd0, 0, "b2b_loaduse"));
    vecs.push_back(mkV(idle, C_RUN, 2'd0, 0, "b2b_after"));
    vecs.push_back(mkV(mkS(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_MCS, 2'd0, 0, "done_with_start"));
    vecs.push_back(mkV(mcq, C_STALL, 2'd2, 0, "done_ignored"));
    vecs.push_back(mkV(mkS(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_RUN, 2'd2, 0, "mc_done2"));
    vecs.push_back(mkV(idle, C_RUN, 2'd0, 0, "mc_done2_run"));
    vecs.push_back(mkV(mcq, C_MCS, 2'd0, 0, "mc_start3"));
    vecs.push_back(mkV(mcq, C_STALL, 2'd2, 0, "mc_wait_pre_rst"));
    vecs.push_back(mkV(mkS(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_RST, 2'd2, 0, "rst_in_mcwait"));
    vecs.push_back(mkV(idle, C_RUN, 2'd0, 0, "rst_mcwait_exit"));

    reset             = 1'b1;
    hz.rs1Addr_id     = '0;
    hz.rs2Addr_id     = '0;
    hz.useRs1_id      = 1'b0;
    hz.useRs2_id      = 1'b0;
    hz.rdAddr_ex      = '0;
    hz.memRead_ex     = 1'b0;
    hz.branchTaken_ex = 1'b0;
    hz.mcReq_ex       = 1'b0;
    hz.mcDone         = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) runVec(vecs[i].in, vecs[i].ctl, vecs[i].st, vecs[i].to, vecs[i].name);

    // Done arriving in the last allowed wait cycle (cnt == MC_TIMEOUT-1) avoids HALT.
    runVec(mcq, C_MCS, 2'd0, 0, "late_start");
    for (int i = 1; i < MC_TIMEOUT - 1; i++) runVec(mcq, C_STALL, 2'd2, 0, "late_wait");
    runVec(mkS(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_RUN, 2'd2, 0, "late_done");
    runVec(idle, C_RUN, 2'd0, 0, "late_run");

    // No done at all: seven wait cycles, then a frozen HALT until reset.
    runVec(mcq, C_MCS, 2'd0, 0, "to_start");
    for (int i = 1; i < MC_TIMEOUT; i++) runVec(mcq, C_STALL, 2'd2, 0, "to_wait");
    runVec(mcq, C_STALL, 2'd3, 1, "halt_entry");
    runVec(mkS(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), C_STALL, 2'd3, 1, "halt_frozen");
    runVec(mkS(0, 5, 0, 1, 0, 5, 1, 0, 0, 0), C_STALL, 2'd3, 1, "halt_no_loaduse");
    runVec(mkS(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_RST, 2'd3, 1, "rst_in_halt");
    runVec(idle, C_RUN, 2'd0, 0, "halt_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end
endmodule
